// File: rtl/rf_access_arbiter.sv
`default_nettype none
// rf_access_arbiter -- two-requester round-robin arbiter in front of a single-port register file,
// which it clears after every reset before serving requests.  Rev 1.0
module rf_access_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Wr0,
  input  logic                  Wr1,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData0,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Ack0,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] RData0,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic                  Ready,
  output logic [ADDR_WIDTH-1:0] RfAddressA,
  output logic [DATA_WIDTH-1:0] RfWriteData,
  output logic                  RfWriteEnable,
  input  logic [DATA_WIDTH-1:0] RfReadDataA
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  grant_id;
  logic                  grant_wr;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  favour_one;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  pick_one;

  // On a tie the pointer decides; otherwise the lone requester wins.
  always_comb begin
    pick_one = 1'b0;
    if (Req0 && Req1) begin
      pick_one = favour_one;
    end else begin
      pick_one = Req1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_INIT;
      clear_addr <= '0;
      favour_one <= 1'b0;
      grant_id   <= 1'b0;
      grant_wr   <= 1'b0;
      grant_addr <= '0;
      grant_data <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clear_addr <= clear_addr + ADDR_ONE;
          if (clear_addr == LAST_ADDR) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (Req0 || Req1) begin
            grant_id   <= pick_one;
            grant_wr   <= pick_one ? Wr1 : Wr0;
            grant_addr <= pick_one ? Addr1 : Addr0;
            grant_data <= pick_one ? WData1 : WData0;
            favour_one <= ~pick_one;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!grant_wr) begin
            if (grant_id) begin
              rdata1_q <= RfReadDataA;
            end else begin
              rdata0_q <= RfReadDataA;
            end
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  always_comb begin
    RfAddressA    = '0;
    RfWriteData   = '0;
    RfWriteEnable = 1'b0;
    case (state)
      ST_INIT: begin
        RfAddressA    = clear_addr;
        RfWriteEnable = 1'b1;
      end
      ST_ACCESS: begin
        RfAddressA    = grant_addr;
        RfWriteData   = grant_data;
        RfWriteEnable = grant_wr;
      end
      default: begin
        RfAddressA    = '0;
      end
    endcase
  end

  assign Ready  = (state != ST_INIT);
  assign Ack0   = (state == ST_DONE) && !grant_id;
  assign Ack1   = (state == ST_DONE) &&  grant_id;
  assign RData0 = rdata0_q;
  assign RData1 = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
`default_nettype none
// tb_rf_access_arbiter -- transaction-level reference model, directed literal checks, random traffic.
// Rev 1.0
module tb_rf_access_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int NREG = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, ready, rf_we;
  logic [DW-1:0] rdata0, rdata1, rf_wdata, rf_rdata;
  logic [AW-1:0] rf_addr;

  logic [DW-1:0] mem [NREG];

  rf_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(clk), .Reset(rst),
    .Req0(req[0]), .Req1(req[1]), .Wr0(wr[0]), .Wr1(wr[1]),
    .Addr0(addr[0]), .Addr1(addr[1]), .WData0(wdata[0]), .WData1(wdata[1]),
    .Ack0(ack0), .Ack1(ack1), .RData0(rdata0), .RData1(rdata1), .Ready(ready),
    .RfAddressA(rf_addr), .RfWriteData(rf_wdata), .RfWriteEnable(rf_we),
    .RfReadDataA(rf_rdata)
  );

  always #5 clk = ~clk;

  assign rf_rdata = mem[rf_addr];
  always @(posedge clk) if (rf_we) mem[rf_addr] <= rf_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: clearing progress, the one transaction in flight and its age, shadow register file.
  bit            model_on = 1'b0;
  int            clear_idx = -1;
  bit            txn_on = 1'b0;
  int            txn_stage = 0;
  int            txn_who = 0;
  bit            txn_wr = 1'b0;
  logic [AW-1:0] txn_addr = '0;
  logic [DW-1:0] txn_data = '0;
  int            last_win = 1;
  logic [DW-1:0] ref_rf [NREG];
  logic [DW-1:0] exp_rd [2];
  bit            e_ready = 1'b0;
  bit            e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [1:0]    e_ack = '0;
  bit            pending [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (e_we) ref_rf[e_addr] = e_wdata;
    if (rst) begin
      model_on  = 1'b1;
      clear_idx = 0;
      txn_on    = 1'b0;
      last_win  = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else if (!model_on) begin
      clear_idx = -1;
    end else if (clear_idx >= 0) begin
      clear_idx++;
      if (clear_idx == NREG) clear_idx = -1;
    end else if (txn_on) begin
      if (txn_stage == 1) begin
        if (!txn_wr) exp_rd[txn_who] = ref_rf[txn_addr];
        txn_stage = 2;
      end else begin
        txn_on = 1'b0;
      end
    end else if (req[0] || req[1]) begin
      if (req[0] && req[1]) txn_who = 1 - last_win;
      else                  txn_who = req[1] ? 1 : 0;
      last_win  = txn_who;
      txn_on    = 1'b1;
      txn_stage = 1;
      txn_wr    = wr[txn_who];
      txn_addr  = addr[txn_who];
      txn_data  = wdata[txn_who];
    end
    e_ready = (clear_idx < 0);
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    e_ack   = '0;
    if (clear_idx >= 0) begin
      e_we   = 1'b1;
      e_addr = clear_idx[AW-1:0];
    end else if (txn_on && txn_stage == 1) begin
      e_we    = txn_wr;
      e_addr  = txn_addr;
      e_wdata = txn_data;
    end else if (txn_on) begin
      e_ack[txn_who] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    if (model_on) begin
      chk("ready", ready, e_ready);
      chk("ack0", ack0, e_ack[0]);
      chk("ack1", ack1, e_ack[1]);
      chk("rf_we", rf_we, e_we);
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_wdata", rf_wdata, e_wdata);
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
    end
  endtask

  task automatic set_req(input int r, input bit on, input bit w, input int a, input int d);
    req[r]   = on;
    wr[r]    = w;
    addr[r]  = a[AW-1:0];
    wdata[r] = d[DW-1:0];
  endtask

  task automatic new_txn(input int r);
    set_req(r, 1'b1, 1'($urandom_range(1)), int'($urandom_range(7)), int'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ids [4];
    int at  [4];
    int got;
    int n;
    int ack1_seen;
    for (int r = 0; r < 2; r++) begin
      set_req(r, 1'b0, 1'b0, 0, 0);
      pending[r] = 1'b0;
      exp_rd[r]  = '0;
    end
    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;

    // Requester 1 read of 9 held through clearing.
    set_req(1, 1'b1, 1'b0, 9, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("init_addr0", rf_addr, 0);
    chk("init_ready0", ready, 0);
    for (int i = 1; i < NREG; i++) begin
      tick();
      chk("init_addr", rf_addr, i);
      chk("init_we", rf_we, 1);
      chk("init_no_ack1", ack1, 0);
    end
    tick();
    chk("ready_rise", ready, 1);
    tick();
    chk("a_acc_addr", rf_addr, 9);
    tick();
    chk("a_ack1", ack1, 1);
    chk("a_rdata1", rdata1, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);

    // Write then read back through requester 0.
    tick();
    set_req(0, 1'b1, 1'b1, 5, 16'hBEEF);
    tick();
    chk("b_acc_addr", rf_addr, 5);
    chk("b_acc_we", rf_we, 1);
    chk("b_acc_wdata", rf_wdata, 16'hBEEF);
    tick();
    chk("b_ack0_wr", ack0, 1);
    set_req(0, 1'b1, 1'b0, 5, 0);
    tick();
    tick();
    tick();
    chk("b_ack0_rd", ack0, 1);
    chk("b_rdata0", rdata0, 16'hBEEF);
    set_req(0, 1'b0, 1'b0, 0, 0);

    // Both requesters held from reset: alternating grants three cycles apart.
    set_req(0, 1'b1, 1'b0, 1, 0);
    set_req(1, 1'b1, 1'b0, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("c_ready", ready, 1);
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      tick();
      if (ack0 || ack1) begin
        ids[got] = ack1 ? 1 : 0;
        at[got]  = cyc;
        got++;
      end
    end
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
    chk("c_count", got, 4);
    chk("c_grant0", ids[0], 0);
    chk("c_grant1", ids[1], 1);
    chk("c_grant2", ids[2], 0);
    chk("c_grant3", ids[3], 1);
    for (int k = 1; k < 4; k++) chk("c_spacing", at[k] - at[k-1], 3);

    // Reset in the middle of a requester 1 write drops it; clearing wipes the write.
    tick();
    set_req(1, 1'b1, 1'b1, 7, 16'h1234);
    tick();
    chk("d_acc_addr", rf_addr, 7);
    chk("d_acc_we", rf_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, 1'b0, 1'b0, 0, 0);
    chk("d_ready", ready, 0);
    chk("d_addr0", rf_addr, 0);
    ack1_seen = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (ack1) ack1_seen++;
    end
    chk("d_no_ack1", ack1_seen, 0);
    set_req(0, 1'b1, 1'b0, 7, 0);
    tick();
    tick();
    chk("d_ack0", ack0, 1);
    chk("d_cleared", rdata0, 0);
    set_req(0, 1'b0, 1'b0, 0, 0);
    tick();

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (pending[r]) begin
          if ((r == 0) ? ack0 : ack1) begin
            if ($urandom_range(1) == 1) new_txn(r);
            else begin
              pending[r] = 1'b0;
              set_req(r, 1'b0, 1'b0, 0, 0);
            end
          end
        end else if ($urandom_range(2) == 0) begin
          new_txn(r);
          pending[r] = 1'b1;
        end
      end
      rst = ($urandom_range(399) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of register-file data words.
REQ-002 Parameter ADDR_WIDTH, default 6, width of register-file addresses (2**ADDR_WIDTH registers).
REQ-003 Clock  in  1  sole clock; all state updates on posedge.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on posedge Clock.
REQ-005 Req0 / Req1  in  1  access request from requester 0 / 1, held high until the matching Ack is seen.
REQ-006 Wr0 / Wr1  in  1  1 = write, 0 = read; valid while Req is high.
REQ-007 Addr0 / Addr1  in  ADDR_WIDTH  target register; valid while Req is high.
REQ-008 WData0 / WData1  in  DATA_WIDTH  write data; valid while Req is high.
REQ-009 Ack0 / Ack1  out  1  one-cycle completion pulse to requester 0 / 1.
REQ-010 RData0 / RData1  out  DATA_WIDTH  registered read result for requester 0 / 1.
REQ-011 Ready  out  1  high once post-reset clearing has completed.
REQ-012 RfAddressA  out  ADDR_WIDTH  register-file read/write address.
REQ-013 RfWriteData  out  DATA_WIDTH  register-file write data.
REQ-014 RfWriteEnable  out  1  register-file write strobe; the write occurs at the next posedge.
REQ-015 RfReadDataA  in  DATA_WIDTH  combinational register-file read data at RfAddressA.

Function
REQ-016 The FSM SHALL have the states INIT, IDLE, ACCESS and DONE.
REQ-017 INIT: a counter steps 0..2**ADDR_WIDTH-1, one step per cycle; each cycle RfAddressA=counter, RfWriteData=0, RfWriteEnable=1; after the last address the FSM goes to IDLE.
REQ-018 Ready SHALL be 0 in INIT and 1 in every other state.
REQ-019 Requests SHALL be ignored in INIT and only sampled in IDLE; a request held through INIT is served after Ready rises.
REQ-020 IDLE: at a posedge with any Req high, the arbiter latches the winner's id, Wr, Addr and WData and moves to ACCESS; with no Req high it stays in IDLE.
REQ-021 Arbitration SHALL be round-robin: with a single request, that requester wins; with both requesting, the requester not granted most recently wins; after reset requester 0 has priority.
REQ-022 ACCESS (one cycle): RfAddressA = latched Addr; RfWriteEnable = latched Wr; RfWriteData = latched WData. For a read, RData of the winner is loaded from RfReadDataA at the closing posedge; for a write, RData is unchanged. The FSM then moves to DONE.
REQ-023 DONE (one cycle): the winner's Ack is 1, the other Ack is 0, no new grant is made, and the FSM then moves to IDLE.
REQ-024 Each requester SHALL deassert Req or present a new transaction by the posedge that ends DONE; the minimum transaction spacing is 3 cycles.
REQ-025 In IDLE and DONE: RfAddressA=0, RfWriteData=0, RfWriteEnable=0.
REQ-026 Ack0 and Ack1 SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per granted transaction.
REQ-027 The round-robin pointer SHALL update on entry to ACCESS.

Reset
REQ-028 A Reset sampled high SHALL force INIT with counter=0, Ready=0, Ack0=Ack1=0, RData0=RData1=0, and the round-robin pointer favouring requester 0, regardless of the current state.
REQ-029 Reset mid-transaction SHALL drop the transaction without an Ack; any write strobed at that edge is later overwritten by INIT clearing.

Verification
REQ-030 Release Reset -> RfWriteEnable high for 64 consecutive cycles with RfAddressA 0..63 in order; Ready rises in the following cycle.
REQ-031 Req0 write Addr0=5, WData0=0xBEEF -> one cycle with RfAddressA=5, RfWriteEnable=1, RfWriteData=0xBEEF; Ack0 pulses in the next cycle; a following Req0 read of Addr0=5 -> RData0=0xBEEF when Ack0 pulses.
REQ-032 Req0 and Req1 held continuously, both reads, from Ready -> grant order 0,1,0,1; Ack pulses spaced 3 cycles apart, never both high.
REQ-033 Req1 read Addr1=9 asserted during INIT -> no Ack1 until after Ready; then Ack1 pulses with RData1=0x0000.
REQ-034 Reset asserted during ACCESS of a Req1 write -> Ack1 never pulses; Ready=0; INIT restarts at RfAddressA=0.
